// File: rtl/ser_tx_0110.sv
// ser_tx_0110 -- serial frame transmitter feeding a 0110 pattern detector.
//
// Each frame is the preamble 0,1,1,0 followed by DATA_W payload bits, sent
// MSB first, one bit per clock. A one-cycle done pulse follows the last bit,
// then the block returns to IDLE.
//
// Optional feature (compile-time macro SER_TX_STUFF_EN):
//   After each payload bit, if the last three emitted bits are 0,1,1, one
//   extra 1 is inserted. The payload section then never contains 0110.
//   When the macro is undefined the STUFF state and bit history are absent.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-low
//   load_valid in   request to start a frame
//   load_data  in   payload [DATA_W-1:0], sampled only on the accepting edge
//   load_ready out  high in IDLE while out of reset (combinational decode)
//   out        out  serial bit (registered)
//   out_valid  out  out carries a frame bit (registered)
//   done       out  one-cycle pulse after the last frame bit (registered)

module ser_tx_0110 #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              out,
    output logic              out_valid,
    output logic              done
);

    // Counter must hold DATA_W-1 and the preamble index 3.
    localparam int unsigned CNT_W   = (DATA_W > 4) ? $clog2(DATA_W) : 2;
    localparam logic [3:0]  PRE_PAT = 4'b0110;  // bit [cnt] is sent while cnt counts 3..0

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        DATA = 3'd2,
        DONE = 3'd3
`ifdef SER_TX_STUFF_EN
        , STUFF = 3'd4
`endif
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;       // bits still to send after the current one
    logic [DATA_W-1:0] shreg, shreg_d;   // MSB is the next payload bit to send
    logic              out_d, out_valid_d, done_d;
`ifdef SER_TX_STUFF_EN
    logic [2:0]        hist, hist_d;     // last three emitted bits, newest in [0]
`endif

    // Ready is a pure state decode, masked while reset is held.
    assign load_ready = rst && (state == IDLE);

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
`ifdef SER_TX_STUFF_EN
            hist      <= '0;
`endif
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            shreg     <= shreg_d;
            out       <= out_d;
            out_valid <= out_valid_d;
            done      <= done_d;
`ifdef SER_TX_STUFF_EN
            hist      <= hist_d;
`endif
        end
    end

    // Next state, counter and shift register.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        shreg_d = shreg;
        case (state)
            IDLE: begin
                if (load_valid && load_ready) begin
                    state_d = PRE;
                    cnt_d   = CNT_W'(3);
                    shreg_d = load_data;
                end
            end
            PRE: begin
                if (cnt == '0) begin
                    state_d = DATA;
                    cnt_d   = CNT_W'(DATA_W - 1);
                    shreg_d = {shreg[DATA_W-2:0], 1'b0};
                end else begin
                    cnt_d   = cnt - CNT_W'(1);
                end
            end
            DATA: begin
`ifdef SER_TX_STUFF_EN
                // hist already includes the data bit on the line now.
                if (hist == 3'b011) begin
                    state_d = STUFF;
                end else
`endif
                if (cnt == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt - CNT_W'(1);
                    shreg_d = {shreg[DATA_W-2:0], 1'b0};
                end
            end
`ifdef SER_TX_STUFF_EN
            STUFF: begin
                // cnt was left untouched on entry, so zero means no data remains.
                if (cnt == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = DATA;
                    cnt_d   = cnt - CNT_W'(1);
                    shreg_d = {shreg[DATA_W-2:0], 1'b0};
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                shreg_d = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                shreg_d = '0;
            end
        endcase
    end

    // Output values for the state being entered, registered with it.
    always_comb begin
        out_d       = 1'b0;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            PRE: begin
                out_d       = PRE_PAT[cnt_d[1:0]];
                out_valid_d = 1'b1;
            end
            DATA: begin
                out_d       = shreg[DATA_W-1];
                out_valid_d = 1'b1;
            end
`ifdef SER_TX_STUFF_EN
            STUFF: begin
                out_d       = 1'b1;
                out_valid_d = 1'b1;
            end
`endif
            DONE:    done_d = 1'b1;
            default: ;
        endcase
`ifdef SER_TX_STUFF_EN
        // Preamble bits are shifted in too, so hist reads 1,1,0 entering DATA.
        hist_d = out_valid_d ? {hist[1:0], out_d} : hist;
`endif
    end

endmodule

// File: tb/tb_ser_tx_0110.sv
// Directed bench for ser_tx_0110 with DATA_W=8; expected frames follow
// SER_TX_STUFF_EN when it is defined for the build.

module tb_ser_tx_0110;

    localparam int unsigned DATA_W = 8;

    logic              clk;
    logic              rst;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              out;
    logic              out_valid;
    logic              done;

    int checks = 0;
    int errors = 0;

    ser_tx_0110 #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .out        (out),
        .out_valid  (out_valid),
        .done       (done)
    );

    // Posedges at 10,20,...; negedges at 5,15,...
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Start a load from a negedge; caller must be in IDLE.
    task automatic send(input logic [7:0] d);
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = d;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_data  = 8'h00;
    endtask

    // Collect frame bits until done (bounded); no comparisons here.
    task automatic capture_frame(output logic [31:0] bits, output int len,
                                 output int gaps, output bit got_done);
        bits     = '0;
        len      = 0;
        gaps     = 0;
        got_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (out_valid) begin
                bits = {bits[30:0], out};
                len++;
            end else begin
                gaps++;
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'hA5;
        #2;
        checks++; if (out !== 1'b0)        begin errors++; $display("FAIL reset_out: got %b expected 0", out); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready: got %b expected 0", load_ready); end
        #13;                    // t=15: release together with dropping load_valid
        rst        = 1'b1;
        load_valid = 1'b0;
        #1;
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL release_load_ready: got %b expected 1", load_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL no_accept_in_reset: out_valid got %b expected 0", out_valid); end
    endtask

    task automatic test_basic_frame();
        logic [31:0] bits;
        int          len, gaps;
        bit          got_done;
        send(8'hA5);
        capture_frame(bits, len, gaps, got_done);
        checks++; if (len !== 12)             begin errors++; $display("FAIL a5_len: got %0d expected 12", len); end
        checks++; if (bits !== 32'h0000_06A5) begin errors++; $display("FAIL a5_bits: got %0h expected 6a5", bits); end
        checks++; if (gaps !== 0)             begin errors++; $display("FAIL a5_gaps: got %0d expected 0", gaps); end
        checks++; if (got_done !== 1'b1)      begin errors++; $display("FAIL a5_done_seen: got %b expected 1", got_done); end
        @(negedge clk);
        checks++; if (done !== 1'b0)          begin errors++; $display("FAIL a5_done_width: got %b expected 0", done); end
        checks++; if (load_ready !== 1'b1)    begin errors++; $display("FAIL a5_ready_after: got %b expected 1", load_ready); end
    endtask

    task automatic test_stuffing();
        logic [7:0]  vals    [3];
        logic [31:0] exp_bits[3];
        int          exp_len [3];
        logic [31:0] bits;
        int          len, gaps;
        bit          got_done;
        vals[0] = 8'h60; vals[1] = 8'hFF; vals[2] = 8'h03;
`ifdef SER_TX_STUFF_EN
        exp_bits[0] = 32'(13'b0110_0111_00000); exp_len[0] = 13;
        exp_bits[1] = 32'(13'b0110_1111_11111); exp_len[1] = 13;
        exp_bits[2] = 32'(13'b0110_0000_00111); exp_len[2] = 13;
`else
        exp_bits[0] = 32'(12'b0110_0110_0000);  exp_len[0] = 12;
        exp_bits[1] = 32'(12'b0110_1111_1111);  exp_len[1] = 12;
        exp_bits[2] = 32'(12'b0110_0000_0011);  exp_len[2] = 12;
`endif
        for (int i = 0; i < 3; i++) begin
            send(vals[i]);
            capture_frame(bits, len, gaps, got_done);
            checks++; if (len !== exp_len[i])   begin errors++; $display("FAIL stuff_len[%0h]: got %0d expected %0d", vals[i], len, exp_len[i]); end
            checks++; if (bits !== exp_bits[i]) begin errors++; $display("FAIL stuff_bits[%0h]: got %0h expected %0h", vals[i], bits, exp_bits[i]); end
            checks++; if (gaps !== 0)           begin errors++; $display("FAIL stuff_gaps[%0h]: got %0d expected 0", vals[i], gaps); end
            checks++; if (got_done !== 1'b1)    begin errors++; $display("FAIL stuff_done[%0h]: got %b expected 1", vals[i], got_done); end
            @(negedge clk);
            checks++; if (load_ready !== 1'b1)  begin errors++; $display("FAIL stuff_idle[%0h]: got %b expected 1", vals[i], load_ready); end
        end
    endtask

    task automatic test_back_to_back();
        // Expected per-cycle waveform: frame A5, DONE, IDLE, frame 81, DONE.
        logic [26:0] exp_o = {12'h6A5, 1'b0, 1'b0, 12'h681, 1'b0};
        logic [26:0] exp_v = {12'hFFF, 1'b0, 1'b0, 12'hFFF, 1'b0};
        logic [26:0] exp_d = {12'h000, 1'b1, 1'b0, 12'h000, 1'b1};
        for (int j = 0; j < 27; j++) begin
            load_valid = 1'b1;
            load_data  = (j == 0) ? 8'hA5 : (j == 14) ? 8'h81 : 8'(j * 29 + 7);
            @(posedge clk);
            @(negedge clk);
            checks++; if (out_valid !== exp_v[26]) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected %b", j, out_valid, exp_v[26]); end
            checks++; if (out !== exp_o[26])       begin errors++; $display("FAIL b2b_out[%0d]: got %b expected %b", j, out, exp_o[26]); end
            checks++; if (done !== exp_d[26])      begin errors++; $display("FAIL b2b_done[%0d]: got %b expected %b", j, done, exp_d[26]); end
            if (j == 5 || j == 13) begin
                checks++;
                if (load_ready !== (j == 13)) begin
                    errors++;
                    $display("FAIL b2b_ready[%0d]: got %b expected %b", j, load_ready, (j == 13));
                end
            end
            exp_o = exp_o << 1;
            exp_v = exp_v << 1;
            exp_d = exp_d << 1;
        end
        load_valid = 1'b0;
        @(negedge clk);
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL b2b_final_idle: got %b expected 1", load_ready); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] bits;
        int          len, gaps;
        bit          got_done;
        bit          saw_done;
        send(8'hA5);
        for (int k = 0; k < 7; k++) @(negedge clk);
        // Third payload bit of A5 (1010_0101) is 1.
        checks++; if (out_valid !== 1'b1 || out !== 1'b1) begin errors++; $display("FAIL mid_third_bit: got valid=%b out=%b expected 1 1", out_valid, out); end
        #1;
        rst = 1'b0;
        #1;
        checks++; if (out !== 1'b0)        begin errors++; $display("FAIL mid_rst_out: got %b expected 0", out); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b expected 0", load_ready); end
        saw_done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done || out_valid) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0)   begin errors++; $display("FAIL mid_no_done: got %b expected 0", saw_done); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after: got %b expected 1", load_ready); end
        send(8'h81);
        capture_frame(bits, len, gaps, got_done);
        checks++; if (len !== 12)             begin errors++; $display("FAIL mid_new_len: got %0d expected 12", len); end
        checks++; if (bits !== 32'h0000_0681) begin errors++; $display("FAIL mid_new_bits: got %0h expected 681", bits); end
        checks++; if (got_done !== 1'b1)      begin errors++; $display("FAIL mid_new_done: got %b expected 1", got_done); end
        @(negedge clk);
    endtask

    initial begin
        load_valid = 1'b0;
        load_data  = '0;
        test_reset();
        test_basic_frame();
        test_stuffing();
        test_back_to_back();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
